mem_port_sequencer: RTL and testbench
=====================================

Name: mem_port_sequencer

Overview:
- Sequences the single shared instruction/data memory port of the multicycle MIPS datapath.
- Two requesters: the instruction-fetch path (FETCH step) and the data path (LW/SW steps).
- Grants one requester at a time, drives memory enable, write and IorD, and counts the fixed memory latency that the control FSM currently covers with hard-wired delay states.
- Pulses the IR or MDR load strobe and a per-requester done when data is valid, so the main control FSM can wait on done instead of counting cycles.

Parameters:
- READ_LAT, 2, cycles from address issue to read data valid (>=1)
- WRITE_LAT, 1, cycles a write must be held on the port (>=1)

Ports:
- Clk  in  1  system clock; all state changes on its rising edge
- Reset  in  1  synchronous, active-low reset
- if_req  in  1  fetch requester wants a read at PC
- if_done  out  1  one-cycle pulse: fetch data valid this cycle
- d_req  in  1  data requester wants an access at ALUOut
- d_we  in  1  data access is a write (SW) when 1, read (LW) when 0
- d_done  out  1  one-cycle pulse: data access complete this cycle
- mem_en  out  1  memory port active
- wr  out  1  memory write strobe
- IorD  out  1  address mux select: 0 = PC, 1 = ALUOut
- IR_load  out  1  load instruction register this cycle
- MDR_load  out  1  load memory data register this cycle
- busy  out  1  access in progress
- StateOut  out  2  debug state: 0 = IDLE, 1 = ACCESS

Behaviour:
- Reset (Reset=0 at a rising edge):
  - state=IDLE, cnt=0, owner=FETCH, we_q=0, last_owner=DATA.
  - Every output reads 0 from the next cycle on.
  - Reset has priority over all other events.
- IDLE:
  - All outputs 0, including IorD.
  - Requests are sampled only in IDLE.
  - If only one request is high, that requester wins.
  - If both are high, the requester not equal to last_owner wins (round robin).
  - On a grant at cycle T: owner, we_q (d_we if owner=DATA, else 0) and last_owner are latched; cnt=0; state=ACCESS at T+1.
- ACCESS:
  - mem_en=1, busy=1, IorD=owner, wr=we_q.
  - LAT = WRITE_LAT if we_q=1, else READ_LAT.
  - cnt increments every cycle.
  - In the cycle where cnt==LAT-1 (the last cycle):
    - owner FETCH: if_done=1 and IR_load=1.
    - owner DATA read: d_done=1 and MDR_load=1.
    - owner DATA write: d_done=1, no load strobe.
  - After the last cycle the next state is IDLE.
- Latency: request sampled at T gives done at T+LAT. There is a mandatory one-cycle IDLE gap between accesses, so a new grant can occur no earlier than T+LAT+1.
- Changes to if_req, d_req or d_we during ACCESS are ignored; the access completes with the latched owner and we_q.
- A requester holding req high through the IDLE cycle after its done is granted again (subject to round robin). Requesters drop req in the cycle after done.
- Reset mid-ACCESS: the access is abandoned, no done or load pulse is produced, state returns to IDLE.
- Counter width: clog2(max(READ_LAT, WRITE_LAT))+1. With LAT=1, the first ACCESS cycle is also the last.
- Outputs are combinational from state, cnt, owner and we_q; there are no registered outputs besides state.

Decomposition:
- Package mem_seq_pkg holds:
  - owner_t enum: OWNER_FETCH=0, OWNER_DATA=1.
  - seq_state_t enum: IDLE=0, ACCESS=1.
  - Default latency constants.
- One sub-module, access_latency_counter: clear, enable and terminal-count compare against a runtime LAT input, with a last output.
- The arbiter and FSM stay in mem_port_sequencer.

Test Plan:
- Reset release, then if_req=1 sampled at cycle 3, READ_LAT=2 -> mem_en=1 and IorD=0 in cycles 4-5; IR_load=1 and if_done=1 only in cycle 5; busy=0 in cycle 6.
- d_req=1 with d_we=1, WRITE_LAT=1, sampled at T -> cycle T+1 has mem_en=1, wr=1, IorD=1, d_done=1, IR_load=0, MDR_load=0; IDLE at T+2.
- if_req and d_req both high right after reset, d_we=0 -> fetch granted first (if_done at T+2); IDLE at T+3; data granted at T+3 with MDR_load and d_done at T+5. Then both high again -> fetch granted.
- Reset=0 in the first ACCESS cycle of a read -> next cycle all outputs 0, StateOut=0; no if_done, d_done or load pulse ever appears for that access.
- During a data read, drop d_req and toggle d_we to 1 in the first ACCESS cycle -> wr stays 0 and MDR_load/d_done still pulse at T+READ_LAT.
- Instance with READ_LAT=4: if_req sampled at T -> mem_en high for exactly T+1..T+4; if_done only at T+4; a held if_req regranted at T+5.

Source files
------------

// File: rtl/mem_seq_pkg.sv
// Shared types and default latencies for the memory port sequencer.
package mem_seq_pkg;

    typedef enum logic {
        OWNER_FETCH = 1'b0,
        OWNER_DATA  = 1'b1
    } owner_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } seq_state_t;

    localparam int DEF_READ_LAT  = 2;
    localparam int DEF_WRITE_LAT = 1;

    // One extra bit so the latency value itself fits in the counter width
    function automatic int cnt_width(input int rd_lat, input int wr_lat);
        int m;
        m = (rd_lat > wr_lat) ? rd_lat : wr_lat;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/access_latency_counter.sv
// Up-counter for memory access cycles; flags the final cycle of an access.
module access_latency_counter
    import mem_seq_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] lat,
    output logic             last
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign last = enable && (cnt == (lat - CNT_W'(1)));

endmodule

// File: rtl/mem_port_sequencer.sv
// Arbitrates fetch and data requesters onto the shared memory port and
// times each access, pulsing the matching done and load strobes.
//
// state  | meaning
// IDLE   | port free; requests sampled, round-robin grant on conflict
// ACCESS | port driven for LAT cycles for the latched owner
module mem_port_sequencer
    import mem_seq_pkg::*;
#(
    parameter int READ_LAT  = DEF_READ_LAT,
    parameter int WRITE_LAT = DEF_WRITE_LAT
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       if_req,
    output logic       if_done,
    input  logic       d_req,
    input  logic       d_we,
    output logic       d_done,
    output logic       mem_en,
    output logic       wr,
    output logic       IorD,
    output logic       IR_load,
    output logic       MDR_load,
    output logic       busy,
    output logic [1:0] StateOut
);

    localparam int CNT_W = cnt_width(READ_LAT, WRITE_LAT);
    localparam logic [CNT_W-1:0] READ_LAT_C  = CNT_W'(READ_LAT);
    localparam logic [CNT_W-1:0] WRITE_LAT_C = CNT_W'(WRITE_LAT);

    seq_state_t state_q, state_d;
    owner_t     owner_q, owner_d;
    owner_t     last_owner_q, last_owner_d;
    logic       we_q, we_d;
    logic       cnt_clear, cnt_en, cnt_last;
    logic [CNT_W-1:0] lat;

    assign lat = we_q ? WRITE_LAT_C : READ_LAT_C;

    access_latency_counter #(.CNT_W(CNT_W)) u_lat_cnt (
        .Clk    (Clk),
        .Reset  (Reset),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .lat    (lat),
        .last   (cnt_last)
    );

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q      <= IDLE;
            owner_q      <= OWNER_FETCH;
            we_q         <= 1'b0;
            last_owner_q <= OWNER_DATA;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            last_owner_q <= last_owner_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        we_d         = we_q;
        last_owner_d = last_owner_q;
        cnt_clear    = 1'b0;
        cnt_en       = 1'b0;
        mem_en       = 1'b0;
        wr           = 1'b0;
        IorD         = 1'b0;
        IR_load      = 1'b0;
        MDR_load     = 1'b0;
        if_done      = 1'b0;
        d_done       = 1'b0;
        busy         = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_clear = 1'b1;
                if (if_req || d_req) begin
                    if (if_req && d_req) begin
                        owner_d = (last_owner_q == OWNER_FETCH) ? OWNER_DATA : OWNER_FETCH;
                    end else begin
                        owner_d = if_req ? OWNER_FETCH : OWNER_DATA;
                    end
                    we_d         = (owner_d == OWNER_DATA) && d_we;
                    last_owner_d = owner_d;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                cnt_en = 1'b1;
                mem_en = 1'b1;
                busy   = 1'b1;
                IorD   = (owner_q == OWNER_DATA);
                wr     = we_q;
                if (cnt_last) begin
                    state_d = IDLE;
                    if (owner_q == OWNER_FETCH) begin
                        if_done = 1'b1;
                        IR_load = 1'b1;
                    end else begin
                        d_done   = 1'b1;
                        MDR_load = !we_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign StateOut = {1'b0, state_q};

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Directed vector bench for mem_port_sequencer: default latencies plus a
// READ_LAT=4 / WRITE_LAT=3 instance for the longer-latency corner cases.
module tb_mem_port_sequencer;

    logic Clk = 1'b0;
    logic Reset;
    logic if_req, d_req, d_we;
    logic if_done, d_done, mem_en, wr, IorD, IR_load, MDR_load, busy;
    logic [1:0] StateOut;

    logic if_req_b, d_req_b, d_we_b;
    logic if_done_b, d_done_b, mem_en_b, wr_b, IorD_b, IR_load_b, MDR_load_b, busy_b;
    logic [1:0] StateOut_b;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    mem_port_sequencer dut_a (
        .Clk(Clk), .Reset(Reset), .if_req(if_req), .if_done(if_done),
        .d_req(d_req), .d_we(d_we), .d_done(d_done), .mem_en(mem_en), .wr(wr),
        .IorD(IorD), .IR_load(IR_load), .MDR_load(MDR_load), .busy(busy),
        .StateOut(StateOut)
    );

    mem_port_sequencer #(.READ_LAT(4), .WRITE_LAT(3)) dut_b (
        .Clk(Clk), .Reset(Reset), .if_req(if_req_b), .if_done(if_done_b),
        .d_req(d_req_b), .d_we(d_we_b), .d_done(d_done_b), .mem_en(mem_en_b), .wr(wr_b),
        .IorD(IorD_b), .IR_load(IR_load_b), .MDR_load(MDR_load_b), .busy(busy_b),
        .StateOut(StateOut_b)
    );

    // {mem_en, wr, IorD, IR_load, MDR_load, if_done, d_done, busy, StateOut}
    localparam logic [9:0] O_IDLE  = 10'b0_0_0_0_0_0_0_0_00;
    localparam logic [9:0] F_MID   = 10'b1_0_0_0_0_0_0_1_01;
    localparam logic [9:0] F_LAST  = 10'b1_0_0_1_0_1_0_1_01;
    localparam logic [9:0] DR_MID  = 10'b1_0_1_0_0_0_0_1_01;
    localparam logic [9:0] DR_LAST = 10'b1_0_1_0_1_0_1_1_01;
    localparam logic [9:0] DW_MID  = 10'b1_1_1_0_0_0_0_1_01;
    localparam logic [9:0] DW_LAST = 10'b1_1_1_0_0_0_1_1_01;

    typedef struct {
        logic       rst;
        logic       ifr;
        logic       dr;
        logic       dwe;
        logic [9:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [9:0] outs_a();
        return {mem_en, wr, IorD, IR_load, MDR_load, if_done, d_done, busy, StateOut};
    endfunction

    function automatic logic [9:0] outs_b();
        return {mem_en_b, wr_b, IorD_b, IR_load_b, MDR_load_b, if_done_b, d_done_b, busy_b, StateOut_b};
    endfunction

    task automatic add(input logic r, input logic i, input logic d, input logic w, input logic [9:0] e);
        vec_t v;
        v.rst = r; v.ifr = i; v.dr = d; v.dwe = w; v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    initial begin
        Reset = 1'b0;
        if_req = 0; d_req = 0; d_we = 0;
        if_req_b = 0; d_req_b = 0; d_we_b = 0;

        // rst, if_req, d_req, d_we, expected outputs in this cycle
        add(0, 0, 0, 0, O_IDLE);   // 0 reset state
        add(1, 0, 0, 0, O_IDLE);
        add(1, 0, 0, 0, O_IDLE);
        add(1, 1, 0, 0, O_IDLE);   // 3 fetch sampled
        add(1, 1, 0, 0, F_MID);
        add(1, 1, 0, 0, F_LAST);
        add(1, 0, 0, 0, O_IDLE);   // 6 not busy
        add(1, 0, 1, 1, O_IDLE);   // 7 data write sampled
        add(1, 0, 0, 0, DW_LAST);
        add(1, 0, 0, 0, O_IDLE);
        add(0, 0, 0, 0, O_IDLE);   // 10 re-reset, last_owner back to DATA
        add(1, 1, 1, 0, O_IDLE);   // 11 both -> fetch
        add(1, 1, 1, 0, F_MID);
        add(1, 1, 1, 0, F_LAST);
        add(1, 0, 1, 0, O_IDLE);   // 14 data read granted
        add(1, 0, 1, 0, DR_MID);
        add(1, 0, 1, 0, DR_LAST);
        add(1, 1, 1, 0, O_IDLE);   // 17 both again -> fetch
        add(1, 0, 1, 0, F_MID);
        add(1, 0, 1, 0, F_LAST);
        add(1, 0, 1, 0, O_IDLE);   // 20 data read
        add(1, 0, 0, 0, DR_MID);
        add(1, 0, 0, 0, DR_LAST);
        add(1, 0, 0, 0, O_IDLE);
        add(1, 1, 0, 0, O_IDLE);   // 24 fetch alone
        add(1, 1, 0, 0, F_MID);
        add(1, 1, 1, 0, F_LAST);
        add(1, 1, 1, 0, O_IDLE);   // 27 both after fetch -> data
        add(1, 1, 0, 0, DR_MID);
        add(1, 1, 0, 0, DR_LAST);
        add(1, 1, 0, 0, O_IDLE);   // 30 held fetch regranted
        add(1, 0, 0, 0, F_MID);
        add(1, 0, 0, 0, F_LAST);
        add(1, 0, 0, 0, O_IDLE);
        add(1, 1, 0, 0, O_IDLE);   // 34 fetch granted
        add(0, 0, 0, 0, F_MID);    // 35 reset in first ACCESS cycle
        add(1, 0, 0, 0, O_IDLE);   // abandoned, no pulses
        add(1, 0, 0, 0, O_IDLE);
        add(1, 0, 0, 0, O_IDLE);
        add(1, 0, 1, 0, O_IDLE);   // 39 data read granted
        add(1, 0, 0, 1, DR_MID);   // d_we toggled mid-access, ignored
        add(1, 0, 0, 1, DR_LAST);
        add(1, 0, 0, 0, O_IDLE);
        add(0, 1, 0, 0, O_IDLE);   // 43 reset beats a grant
        add(1, 0, 0, 0, O_IDLE);
        add(1, 0, 0, 0, O_IDLE);

        repeat (2) @(posedge Clk);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge Clk);
            Reset  = tbl[i].rst;
            if_req = tbl[i].ifr;
            d_req  = tbl[i].dr;
            d_we   = tbl[i].dwe;
            #1;
            chk($sformatf("vec%0d", i), outs_a(), tbl[i].exp);
        end

        @(negedge Clk);
        Reset = 1'b1; if_req = 0; d_req = 0; d_we = 0;

        // Long read: held if_req, done at T+4, regrant sampled at T+5
        @(negedge Clk);
        if_req_b = 1'b1;
        #1 chk("b_idle_pre", outs_b(), O_IDLE);
        for (int k = 1; k <= 4; k++) begin
            @(negedge Clk);
            #1 chk($sformatf("b_read_c%0d", k), outs_b(), (k == 4) ? F_LAST : F_MID);
        end
        @(negedge Clk);
        #1 chk("b_gap", outs_b(), O_IDLE);
        @(negedge Clk);
        if_req_b = 1'b0;
        #1 chk("b_regrant", outs_b(), F_MID);

        begin
            int waited;
            waited = 0;
            while (waited < 8 && if_done_b !== 1'b1) begin
                @(negedge Clk);
                #1 waited++;
            end
            checks++;
            if (waited != 3) begin
                errors++;
                $display("FAIL b_regrant_done: waited %0d cycles required 3", waited);
            end
        end
        @(negedge Clk);
        #1 chk("b_idle_post", outs_b(), O_IDLE);

        // Three-cycle write on the long-latency instance
        d_req_b = 1'b1; d_we_b = 1'b1;
        #1 chk("b_w_idle", outs_b(), O_IDLE);
        @(negedge Clk);
        d_req_b = 1'b0; d_we_b = 1'b0;
        #1 chk("b_w_c1", outs_b(), DW_MID);
        @(negedge Clk);
        #1 chk("b_w_c2", outs_b(), DW_MID);
        @(negedge Clk);
        #1 chk("b_w_c3", outs_b(), DW_LAST);
        @(negedge Clk);
        #1 chk("b_w_end", outs_b(), O_IDLE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
